tx_char_queue: RTL and testbench

// Output-side stage between the Enigma datapath/menu FSM and uart_tx. Buffers outgoing bytes in a FIFO so

---
 rtl/tx_char_queue.sv | 192 +++++++++++++++++++
 tb/tb_tx_char_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_char_queue.sv
// rtl/tx_char_queue.sv - output byte FIFO pacing uart_tx, with optional 5-letter grouping
// Separators are lazy: they are only emitted once the next letter is already queued.
module tx_char_queue #(
  parameter int DEPTH           = 16,
  parameter int ADDR_W          = 4,
  parameter int GROUP_LEN       = 5,
  parameter int GROUPS_PER_LINE = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              group_en,
  input  logic              flush,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int CW = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam int GW = (GROUPS_PER_LINE > 1) ? $clog2(GROUPS_PER_LINE) : 1;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, SEND_LF} state_t;
  state_t state_q, state_d;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [7:0]        head;
  logic              head_letter;
  logic              wr_en, pop;

  logic [7:0]        hold_q;
  logic              hold_letter_q, hold_cr_q;
  logic              load, load_letter, load_cr;
  logic [7:0]        load_byte;
  logic              clr_cnt, sep_take, bump;

  logic [CW-1:0]     char_cnt_q;
  logic [GW-1:0]     grp_cnt_q;
  logic              sep_pending_q, sep_crlf_q;

  logic              tx_start_q, overflow_q;
  logic [7:0]        tx_din_q;

  assign in_ready    = (count_q < FULL_CNT);
  assign wr_en       = in_valid && in_ready && !flush;
  assign head        = mem[rd_ptr_q];
  assign head_letter = (head >= 8'h41) && (head <= 8'h5A);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= in_valid && !in_ready && !flush;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        count_q <= count_q + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, pop};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load        = 1'b0;
    load_byte   = 8'h00;
    load_letter = 1'b0;
    load_cr     = 1'b0;
    clr_cnt     = 1'b0;
    sep_take    = 1'b0;
    bump        = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !tx_active && !flush) begin
          load    = 1'b1;
          state_d = LAUNCH;
          if (sep_pending_q && head_letter && group_en) begin
            // The separator goes out ahead of the letter, which stays queued.
            load_byte = sep_crlf_q ? CH_CR : CH_SP;
            load_cr   = sep_crlf_q;
            sep_take  = 1'b1;
          end else if (!head_letter) begin
            pop       = 1'b1;
            load_byte = head;
            clr_cnt   = 1'b1;
          end else begin
            pop         = 1'b1;
            load_byte   = head;
            load_letter = 1'b1;
          end
        end
      end
      LAUNCH: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          bump    = hold_letter_q && group_en;
          state_d = hold_cr_q ? SEND_LF : IDLE;
        end
      end
      SEND_LF: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!tx_active) begin
          load      = 1'b1;
          load_byte = CH_LF;
          state_d   = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= 8'h00;
      hold_letter_q <= 1'b0;
      hold_cr_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_din_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_start_q <= (state_q == LAUNCH);
      if (state_q == LAUNCH) tx_din_q <= hold_q;
      if (load) begin
        hold_q        <= load_byte;
        hold_letter_q <= load_letter;
        hold_cr_q     <= load_cr;
      end else if (flush) begin
        // A flushed CR must not be followed by its LF.
        hold_cr_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_cnt_q    <= '0;
      grp_cnt_q     <= '0;
      sep_pending_q <= 1'b0;
      sep_crlf_q    <= 1'b0;
    end else if (flush || clr_cnt) begin
      char_cnt_q    <= '0;
      grp_cnt_q     <= '0;
      sep_pending_q <= 1'b0;
      sep_crlf_q    <= 1'b0;
    end else if (!group_en || sep_take) begin
      sep_pending_q <= 1'b0;
    end else if (bump) begin
      if (char_cnt_q == CW'(GROUP_LEN - 1)) begin
        char_cnt_q    <= '0;
        sep_pending_q <= 1'b1;
        if (grp_cnt_q == GW'(GROUPS_PER_LINE - 1)) begin
          grp_cnt_q  <= '0;
          sep_crlf_q <= 1'b1;
        end else begin
          grp_cnt_q  <= grp_cnt_q + GW'(1);
          sep_crlf_q <= 1'b0;
        end
      end else begin
        char_cnt_q <= char_cnt_q + CW'(1);
      end
    end
  end

  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tx_char_queue.sv
// tb/tb_tx_char_queue.sv - scoreboard bench for tx_char_queue with a 20-cycle uart_tx model
module tb_tx_char_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       group_en = 1'b0;
  logic       flush = 1'b0;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_active;
  logic       tx_done = 1'b0;
  logic [4:0] count;
  logic       overflow;

  tx_char_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .group_en(group_en), .flush(flush), .tx_start(tx_start), .tx_din(tx_din),
    .tx_active(tx_active), .tx_done(tx_done), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  bit         m_ge = 1'b0;
  int         m_run = 0;

  logic       busy = 1'b0;
  logic       force_busy = 1'b0;
  int         remain = 0;
  int         launches = 0;
  int         dones = 0;
  int         ovf_pulses = 0;
  int         launch_cyc = 0;
  logic [7:0] last_launch = 8'h00;
  assign tx_active = busy | force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: separators depend only on the number of letters since the last non-letter.
  task automatic model_push(input logic [7:0] b);
    bit is_letter;
    is_letter = (b >= 8'h41) && (b <= 8'h5A);
    if (!m_ge) begin
      exp_q.push_back(b);
    end else if (!is_letter) begin
      m_run = 0;
      exp_q.push_back(b);
    end else begin
      if (m_run > 0 && m_run % 25 == 0) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else if (m_run > 0 && m_run % 5 == 0) begin
        exp_q.push_back(8'h20);
      end
      exp_q.push_back(b);
      m_run++;
    end
  endtask

  // Monitor and uart_tx model share one process to avoid ordering races.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy    = 1'b0;
      tx_done = 1'b0;
      remain  = 0;
    end else begin
      if (overflow) ovf_pulses++;
      if (tx_done) tx_done = 1'b0;
      if (busy) begin
        remain--;
        if (remain == 0) begin
          busy    = 1'b0;
          tx_done = 1'b1;
          dones++;
          chk("tx_din_hold", tx_din, last_launch);
        end
      end
      if (tx_start) begin
        chk("start_while_active", tx_active, 0);
        launches++;
        launch_cyc  = cyc;
        last_launch = tx_din;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_start actual=%0h required=none", tx_din);
        end else begin
          chk("tx_byte", tx_din, exp_q.pop_front());
        end
        busy   = 1'b1;
        remain = 20;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    int g = 0;
    while (!in_ready && g < 2000) begin tick(1); g++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL put_timeout actual=not_ready required=ready");
    end else begin
      in_data  = b;
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      model_push(b);
    end
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic wait_launch(input int target);
    int g = 0;
    while (launches < target && g < 500) begin tick(1); g++; end
    chk("launch_reached", (launches >= target), 1);
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 6000) begin tick(1); g++; end
    chk({"drain_", tag}, exp_q.size(), 0);
    tick(30);
    chk({"count_after_", tag}, count, 0);
  endtask

  task automatic set_mode(input bit ge);
    flush = 1'b1;
    tick(1);
    flush    = 1'b0;
    group_en = ge;
    m_ge     = ge;
    m_run    = 0;
    exp_q.delete();
  endtask

  initial begin
    int acc, l0, d0, o0, n;
    logic [7:0] b;

    // Reset state
    tick(3);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_din", tx_din, 8'h00);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_tx_start", tx_start, 0);
    chk("post_rst_count", count, 0);

    // Launch latency from an idle, empty queue
    set_mode(1'b0);
    l0 = launches;
    put(8'h51);
    acc = cyc;
    wait_launch(l0 + 1);
    chk("launch_latency", launch_cyc - acc, 2);
    drain("latency");

    // Grouping cases
    set_mode(1'b1);
    put_str("ABCDEFG");
    drain("abcdefg");
    set_mode(1'b1);
    put_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ");
    drain("alphabet");
    set_mode(1'b1);
    put_str("ABC");
    put(8'h0D);
    put_str("DEFGHI");
    drain("cr_clears");

    // Full FIFO with transmitter held busy
    set_mode(1'b0);
    force_busy = 1'b1;
    l0 = launches;
    o0 = ovf_pulses;
    for (int i = 0; i < 17; i++) begin
      in_data  = 8'h61 + 8'(i);
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      if (i < 16) model_push(8'h61 + 8'(i));
    end
    tick(2);
    chk("full_count", count, 16);
    chk("full_in_ready", in_ready, 0);
    chk("overflow_pulses", ovf_pulses - o0, 1);
    chk("no_launch_while_active", launches - l0, 0);
    force_busy = 1'b0;
    drain("full");

    // Flush while the third byte is in flight; a same-cycle write is ignored
    set_mode(1'b0);
    l0 = launches;
    put_str("0123456789");
    wait_launch(l0 + 3);
    tick(5);
    d0       = dones;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    m_run = 0;
    tick(40);
    chk("flush_inflight_done", dones - d0, 1);
    chk("flush_launches", launches - l0, 3);
    chk("flush_count", count, 0);

    // Asynchronous reset mid-byte
    l0 = launches;
    put_str("vwxyz");
    wait_launch(l0 + 2);
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_tx_start", tx_start, 0);
    chk("arst_tx_din", tx_din, 8'h00);
    chk("arst_in_ready", in_ready, 1);
    exp_q.delete();
    m_run = 0;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    chk("arst_no_launch", launches - l0, 2);

    // Randomised traffic, grouped then verbatim
    for (int ph = 0; ph < 2; ph++) begin
      set_mode(ph == 0);
      for (int k = 0; k < 80; k++) begin
        n = $urandom_range(0, 9);
        if (n < 8) b = 8'h41 + 8'($urandom_range(0, 25));
        else if (n == 8) b = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h0D;
        else b = 8'h30 + 8'($urandom_range(0, 9));
        put(b);
        if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 30));
      end
      drain(ph == 0 ? "rand_grouped" : "rand_verbatim");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
